// File: rtl/instruction_fetch_pkg.sv
// instruction_fetch_pkg: shared state encoding, IF/ID record and defaults for the fetch stage.
package instruction_fetch_pkg;

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_HOLD, S_KILL, S_ERR} state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        valid;
        logic        adel;
    } if_id_t;

    localparam logic [31:0] DEF_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] DEF_NOP_INST     = 32'h0000_0000;

    function automatic logic misaligned(input logic [31:0] pc);
        return pc[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC register and IF stage feeding IF/ID over a req/ack instruction bus,
// with hold buffer for stalled acks, wrong-path kill, redirects and misaligned-PC marking.
module instruction_fetch
    import instruction_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [31:0] NOP_INST     = DEF_NOP_INST
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_stall,
    output logic [31:0] o_pc,
    input  logic [31:0] i_bp_next_pc,
    input  logic        i_bp_flush,
    input  logic        i_exc_flush,
    input  logic [31:0] i_exc_vector,
    output logic        o_ibus_req,
    output logic [31:0] o_ibus_addr,
    input  logic        i_ibus_ack,
    input  logic [31:0] i_ibus_data,
    output logic        o_if_stall,
    output logic [31:0] o_id_pc,
    output logic [31:0] o_id_inst,
    output logic        o_id_valid,
    output logic        o_id_exc_adel
);

    state_t      r_state, w_state;
    logic [31:0] r_pc, w_pc;
    logic [31:0] r_kill_addr;
    logic [31:0] r_hold_pc, w_hold_pc;
    logic [31:0] r_hold_data, w_hold_data;
    logic        r_hold_valid, w_hold_valid;
    logic        r_err_sent, w_err_sent;
    logic        w_fetch_req, w_accept;
    if_id_t      r_id, w_id, w_bubble;

    assign w_fetch_req = r_state == S_FETCH && !misaligned(r_pc);
    assign o_ibus_req  = w_fetch_req || r_state == S_KILL;
    assign o_ibus_addr = r_state == S_KILL ? r_kill_addr : {r_pc[31:2], 2'b00};
    assign o_if_stall  = !w_accept;
    assign o_pc        = r_pc;
    assign o_id_pc       = r_id.pc;
    assign o_id_inst     = r_id.inst;
    assign o_id_valid    = r_id.valid;
    assign o_id_exc_adel = r_id.adel;

    always_comb begin
        w_bubble     = '{pc: r_id.pc, inst: NOP_INST, valid: 1'b0, adel: 1'b0};
        w_state      = r_state;
        w_pc         = r_pc;
        w_id         = r_id;
        w_hold_pc    = r_hold_pc;
        w_hold_data  = r_hold_data;
        w_hold_valid = r_hold_valid;
        w_err_sent   = r_err_sent;
        w_accept     = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_state = S_FETCH;
                if (!i_stall) w_id = w_bubble;
            end
            S_FETCH: begin
                if (misaligned(r_pc)) begin
                    w_state    = S_ERR;
                    w_err_sent = 1'b0;
                    if (!i_stall) w_id = w_bubble;
                end else if (i_ibus_ack && !i_stall) begin
                    w_id     = '{pc: r_pc, inst: i_ibus_data, valid: 1'b1, adel: 1'b0};
                    w_pc     = i_bp_next_pc;
                    w_accept = 1'b1;
                end else if (i_ibus_ack) begin
                    // ID is stalled: park the word so the bus transaction can complete
                    w_hold_pc    = r_pc;
                    w_hold_data  = i_ibus_data;
                    w_hold_valid = 1'b1;
                    w_state      = S_HOLD;
                end else if (!i_stall) begin
                    w_id = w_bubble;
                end
            end
            S_HOLD: begin
                if (!i_stall) begin
                    w_id         = '{pc: r_hold_pc, inst: r_hold_data, valid: r_hold_valid, adel: 1'b0};
                    w_hold_valid = 1'b0;
                    w_pc         = i_bp_next_pc;
                    w_accept     = 1'b1;
                    w_state      = S_FETCH;
                end
            end
            S_KILL: begin
                if (i_ibus_ack) w_state = S_FETCH;
                if (!i_stall) w_id = w_bubble;
            end
            S_ERR: begin
                if (!i_stall) begin
                    w_id       = r_err_sent ? w_bubble : '{pc: r_pc, inst: NOP_INST, valid: 1'b1, adel: 1'b1};
                    w_err_sent = 1'b1;
                end
            end
            default: w_state = S_IDLE;
        endcase
        // Redirects win over stall; an unacked request must still be seen through in KILL
        if (i_exc_flush || i_bp_flush) begin
            w_pc         = i_exc_flush ? i_exc_vector : i_bp_next_pc;
            w_id         = w_bubble;
            w_hold_valid = 1'b0;
            w_accept     = 1'b0;
            w_state      = (o_ibus_req && !i_ibus_ack) ? S_KILL : S_FETCH;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_pc         <= RESET_VECTOR;
            r_kill_addr  <= 32'h0;
            r_hold_pc    <= 32'h0;
            r_hold_data  <= NOP_INST;
            r_hold_valid <= 1'b0;
            r_err_sent   <= 1'b0;
            r_id         <= '{pc: 32'h0, inst: NOP_INST, valid: 1'b0, adel: 1'b0};
        end else begin
            r_state      <= w_state;
            r_pc         <= w_pc;
            r_kill_addr  <= o_ibus_addr;
            r_hold_pc    <= w_hold_pc;
            r_hold_data  <= w_hold_data;
            r_hold_valid <= w_hold_valid;
            r_err_sent   <= w_err_sent;
            r_id         <= w_id;
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: random stall/flush/bus-latency stimulus checked against an
// architectural model of the in-order fetch stream seen by ID.
module tb_instruction_fetch;

    localparam logic [31:0] RV  = 32'hBFC0_0000;
    localparam logic [31:0] NOP = 32'h0000_0000;

    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, bp_flush = 1'b0, exc_flush = 1'b0;
    logic [31:0] exc_vector = 32'h0, flush_tgt = 32'h0;
    logic [31:0] pc, bp_next, ibus_addr, ibus_data, id_pc, id_inst;
    logic        ibus_req, ibus_ack, if_stall, id_valid, id_adel;
    int          vectors = 0, errors = 0;
    int unsigned lat_max = 0, cnt = 0, lat = 0;

    always #5 clk = ~clk;

    instruction_fetch dut (
        .clk(clk), .rst(rst), .i_stall(stall), .o_pc(pc), .i_bp_next_pc(bp_next),
        .i_bp_flush(bp_flush), .i_exc_flush(exc_flush), .i_exc_vector(exc_vector),
        .o_ibus_req(ibus_req), .o_ibus_addr(ibus_addr), .i_ibus_ack(ibus_ack),
        .i_ibus_data(ibus_data), .o_if_stall(if_stall), .o_id_pc(id_pc),
        .o_id_inst(id_inst), .o_id_valid(id_valid), .o_id_exc_adel(id_adel)
    );

    function automatic logic [31:0] pred(input logic [31:0] a);
        return (a[6:2] == 5'd9) ? a + 32'h40 : a + 32'h4;
    endfunction

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'hC3A5_5A3C;
    endfunction

    // predictor and memory models
    assign bp_next   = bp_flush ? flush_tgt : pred(pc);
    assign ibus_ack  = ibus_req && (cnt >= lat);
    assign ibus_data = ibus_ack ? mem_word(ibus_addr) : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (rst || (ibus_req && ibus_ack)) begin
            cnt <= 0;
            lat <= $urandom_range(lat_max);
        end else if (ibus_req) begin
            cnt <= cnt + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pick_vector();
        case ($urandom_range(3))
            0: return 32'h8000_0182;
            1: return 32'h8000_0180;
            default: return {16'h8000, 14'($urandom), 2'b00};
        endcase
    endfunction

    logic [31:0] exp_pc, prev_pc, prev_addr, prev_id_pc, prev_id_inst;
    logic        err_done, have_prev, prev_if_stall, prev_flush, prev_pend, prev_hold;
    logic        prev_id_valid, consume;
    int          idle, delivered;

    initial begin
        repeat (2) @(negedge clk);
        check("rst_pc", pc, RV);
        check("rst_req", 32'(ibus_req), 0);
        check("rst_id_valid", 32'(id_valid), 0);
        check("rst_id_inst", id_inst, NOP);
        check("rst_id_pc", id_pc, 0);
        check("rst_id_adel", 32'(id_adel), 0);
        check("rst_if_stall", 32'(if_stall), 1);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("zw_id_pc", id_pc, RV + 32'(4 * i));
            check("zw_id_inst", id_inst, mem_word(RV + 32'(4 * i)));
            check("zw_id_valid", 32'(id_valid), 1);
            check("zw_if_stall", 32'(if_stall), 0);
        end
        // reset again mid-stream, then randomised run with a slow bus
        lat_max = 3;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        exp_pc = RV; err_done = 1'b0; have_prev = 1'b0; idle = 0; delivered = 0;
        for (int c = 0; c < 4000; c++) begin
            @(negedge clk);
            if (have_prev) begin
                if (prev_pend) begin
                    check("req_held", 32'(ibus_req), 1);
                    check("addr_held", ibus_addr, prev_addr);
                end
                if (!prev_flush) check("pc_step", pc, prev_if_stall ? prev_pc : pred(prev_pc));
                if (prev_hold) begin
                    check("stall_id_pc", id_pc, prev_id_pc);
                    check("stall_id_inst", id_inst, prev_id_inst);
                    check("stall_id_valid", 32'(id_valid), 32'(prev_id_valid));
                end
            end
            if (ibus_req) check("addr_align", 32'(ibus_addr[1:0]), 0);
            if (err_done) begin
                check("err_no_req", 32'(ibus_req), 0);
                check("err_pc_frozen", pc, exp_pc);
            end
            if (!id_valid) begin
                check("bubble_inst", id_inst, NOP);
                check("bubble_adel", 32'(id_adel), 0);
            end
            stall      = ($urandom_range(3) == 0);
            exc_flush  = err_done ? ($urandom_range(4) == 0) : ($urandom_range(39) == 0);
            bp_flush   = ($urandom_range(24) == 0);
            exc_vector = pick_vector();
            flush_tgt  = {16'hBFC0, 14'($urandom), 2'b00};
            consume    = !stall && !bp_flush && !exc_flush && id_valid;
            if (consume) begin
                check("id_pc", id_pc, exp_pc);
                if (exp_pc[1:0] != 2'b00) begin
                    check("err_once", 32'(err_done), 0);
                    check("err_inst", id_inst, NOP);
                    check("err_adel", 32'(id_adel), 1);
                    err_done = 1'b1;
                end else begin
                    check("id_inst", id_inst, mem_word(exp_pc));
                    check("id_adel", 32'(id_adel), 0);
                    exp_pc = pred(exp_pc);
                    delivered++;
                end
                idle = 0;
            end
            if (exc_flush || bp_flush) begin
                exp_pc   = exc_flush ? exc_vector : flush_tgt;
                err_done = 1'b0;
                idle     = 0;
            end else if (!stall && !err_done && !consume) begin
                idle++;
                if (idle > 40) begin
                    check("progress", 32'(idle), 0);
                    idle = 0;
                end
            end
            prev_hold     = stall && !bp_flush && !exc_flush;
            prev_id_pc    = id_pc;
            prev_id_inst  = id_inst;
            prev_id_valid = id_valid;
            #1;
            if (bp_flush || exc_flush) check("flush_if_stall", 32'(if_stall), 1);
            prev_if_stall = if_stall;
            prev_pc       = pc;
            prev_flush    = bp_flush || exc_flush;
            prev_pend     = ibus_req && !ibus_ack;
            prev_addr     = ibus_addr;
            have_prev     = 1'b1;
        end
        check("enough_delivered", 32'(delivered >= 200), 1);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
